riesgo_carga_sb: RTL and testbench

Parametrised load-use hazard unit with a per-register scoreboard. It sits between decode and execute in the pipeline. Each cycle it compares the source operands of the instruction in decode against loads that have not yet delivered data, and inserts bubbles for exactly as many cycles as the configured memory latency requires. A branch flush input suppresses stalls, and an optional stall-cycle statistics counter is available.

---
 rtl/riesgo_carga_sb.sv | 92 +++++++++
 tb/tb_riesgo_carga_sb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/riesgo_carga_sb.sv
// Load-use hazard unit with a per-register countdown scoreboard between decode and Exe.
// Optional stall statistics counter enabled by defining RIESGO_STATS_EN.
module riesgo_carga_sb #(
  parameter int REG_AW  = 4,
  parameter int MEM_LAT = 1,
  parameter int STAT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_AW-1:0]    ra_dec,
  input  logic                 re_a_dec,
  input  logic [REG_AW-1:0]    rb_dec,
  input  logic                 re_b_dec,
  input  logic [REG_AW-1:0]    rd_exe,
  input  logic                 mem_re_exe,
  input  logic                 flush,
  output logic                 nop_mux,
  output logic                 f_reg_en,
  output logic                 pc_en,
  output logic [2**REG_AW-1:0] busy,
  output logic [STAT_W-1:0]    stall_cnt
);

  localparam int NREG = 2**REG_AW;
  localparam logic [2:0] RELOAD = 3'(MEM_LAT - 1);

  logic [2:0] cnt_q [NREG];
  logic [2:0] cnt_d [NREG];

  logic load_ok;
  logic exe_hit_a, exe_hit_b;
  logic hit_a, hit_b;
  logic stall;

  // A load is only tracked when it survives this cycle and targets a real register.
  assign load_ok = mem_re_exe && !flush && (rd_exe != '0);

  assign exe_hit_a = mem_re_exe && (rd_exe == ra_dec);
  assign exe_hit_b = mem_re_exe && (rd_exe == rb_dec);

  assign hit_a = re_a_dec && (ra_dec != '0) && (exe_hit_a || (cnt_q[ra_dec] != 3'd0));
  assign hit_b = re_b_dec && (rb_dec != '0) && (exe_hit_b || (cnt_q[rb_dec] != 3'd0));

  assign stall    = (hit_a || hit_b) && !flush && !rst;
  assign nop_mux  = stall;
  assign f_reg_en = !stall;
  assign pc_en    = !stall;

  // Reload beats decrement, so a newer load to the same register restarts its window.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = 3'd0;
      if (r != 0) begin
        if (load_ok && (rd_exe == REG_AW'(r)))
          cnt_d[r] = RELOAD;
        else if (cnt_q[r] != 3'd0)
          cnt_d[r] = cnt_q[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= 3'd0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    assign busy[gi] = (cnt_q[gi] != 3'd0);
  end

`ifdef RIESGO_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  // Saturating count of bubble cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != {STAT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riesgo_carga_sb.sv
// Directed bench for riesgo_carga_sb: MEM_LAT=1, MEM_LAT=3 and MEM_LAT=3/STAT_W=2 instances share stimulus.
module tb_riesgo_carga_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ra_dec, rb_dec, rd_exe;
  logic       re_a_dec, re_b_dec, mem_re_exe, flush;

  logic        a_nop, a_fen, a_pen;
  logic [15:0] a_busy, a_scnt;
  logic        b_nop, b_fen, b_pen;
  logic [15:0] b_busy, b_scnt;
  logic        c_nop, c_fen, c_pen;
  logic [15:0] c_busy;
  logic [1:0]  c_scnt;

  int checks = 0;
  int errors = 0;

`ifdef RIESGO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  riesgo_carga_sb #(.REG_AW(4), .MEM_LAT(1), .STAT_W(16)) u_a (
    .clk(clk), .rst(rst), .ra_dec(ra_dec), .re_a_dec(re_a_dec), .rb_dec(rb_dec),
    .re_b_dec(re_b_dec), .rd_exe(rd_exe), .mem_re_exe(mem_re_exe), .flush(flush),
    .nop_mux(a_nop), .f_reg_en(a_fen), .pc_en(a_pen), .busy(a_busy), .stall_cnt(a_scnt));

  riesgo_carga_sb #(.REG_AW(4), .MEM_LAT(3), .STAT_W(16)) u_b (
    .clk(clk), .rst(rst), .ra_dec(ra_dec), .re_a_dec(re_a_dec), .rb_dec(rb_dec),
    .re_b_dec(re_b_dec), .rd_exe(rd_exe), .mem_re_exe(mem_re_exe), .flush(flush),
    .nop_mux(b_nop), .f_reg_en(b_fen), .pc_en(b_pen), .busy(b_busy), .stall_cnt(b_scnt));

  riesgo_carga_sb #(.REG_AW(4), .MEM_LAT(3), .STAT_W(2)) u_c (
    .clk(clk), .rst(rst), .ra_dec(ra_dec), .re_a_dec(re_a_dec), .rb_dec(rb_dec),
    .re_b_dec(re_b_dec), .rd_exe(rd_exe), .mem_re_exe(mem_re_exe), .flush(flush),
    .nop_mux(c_nop), .f_reg_en(c_fen), .pc_en(c_pen), .busy(c_busy), .stall_cnt(c_scnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic stl, input logic [15:0] bsy);
    chk({tag, "_a_nop"}, 32'(a_nop), 32'(stl));
    chk({tag, "_a_fen"}, 32'(a_fen), 32'(!stl));
    chk({tag, "_a_pen"}, 32'(a_pen), 32'(!stl));
    chk({tag, "_a_busy"}, 32'(a_busy), 32'(bsy));
    $display("step %s lat1: nop=%0d busy=%h", tag, a_nop, a_busy);
  endtask

  task automatic chk_b(input string tag, input logic stl, input logic [15:0] bsy);
    chk({tag, "_b_nop"}, 32'(b_nop), 32'(stl));
    chk({tag, "_b_fen"}, 32'(b_fen), 32'(!stl));
    chk({tag, "_b_pen"}, 32'(b_pen), 32'(!stl));
    chk({tag, "_b_busy"}, 32'(b_busy), 32'(bsy));
    $display("step %s lat3: nop=%0d busy=%h", tag, b_nop, b_busy);
  endtask

  task automatic drive(input logic [3:0] ra, input logic rea, input logic [3:0] rb,
                       input logic reb, input logic [3:0] rd, input logic mre, input logic fl);
    ra_dec = ra; re_a_dec = rea; rb_dec = rb; re_b_dec = reb;
    rd_exe = rd; mem_re_exe = mre; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a matching load presented: nothing may stall or register
    rst = 1'b1;
    drive(4'd5, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    chk_a("rst1", 1'b0, 16'h0000);
    chk_b("rst1", 1'b0, 16'h0000);
    tick();
    chk_b("rst2", 1'b0, 16'h0000);
    rst = 1'b0;
    drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk_a("idle", 1'b0, 16'h0000);
    chk_b("idle", 1'b0, 16'h0000);
    chk("rst_a_scnt", 32'(a_scnt), 32'd0);
    chk("rst_b_scnt", 32'(b_scnt), 32'd0);
    chk("rst_c_scnt", 32'(c_scnt), 32'd0);

    // load r5 with dependent A operand
    tick();
    drive(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    chk_a("ld5_t0", 1'b1, 16'h0000);
    chk_b("ld5_t0", 1'b1, 16'h0000);
    tick();
    drive(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk_a("ld5_t1", 1'b0, 16'h0000);
    chk_b("ld5_t1", 1'b1, 16'h0020);
    tick();
    chk_b("ld5_t2", 1'b1, 16'h0020);
    tick();
    chk_a("ld5_t3", 1'b0, 16'h0000);
    chk_b("ld5_t3", 1'b0, 16'h0000);

    // load r7 with dependent B operand
    tick();
    drive(4'd0, 1'b0, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0);
    chk_b("ld7_t0", 1'b1, 16'h0000);
    tick();
    drive(4'd0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    chk_a("ld7_t1", 1'b0, 16'h0000);
    chk_b("ld7_t1", 1'b1, 16'h0080);
    tick();
    chk_b("ld7_t2", 1'b1, 16'h0080);
    tick();
    chk_b("ld7_t3", 1'b0, 16'h0000);

    // matching register but operand not read
    tick();
    drive(4'd9, 1'b0, 4'd9, 1'b0, 4'd9, 1'b1, 1'b0);
    chk_a("noread", 1'b0, 16'h0000);
    chk_b("noread", 1'b0, 16'h0000);
    tick();
    drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk_b("noread_busy", 1'b0, 16'h0200);
    tick();
    tick();
    chk_b("noread_clr", 1'b0, 16'h0000);

    // load to r0 never hazards and never goes busy
    drive(4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
    chk_a("r0_ld", 1'b0, 16'h0000);
    chk_b("r0_ld", 1'b0, 16'h0000);
    tick();
    drive(4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk_b("r0_after", 1'b0, 16'h0000);

    // pending r3, then a flushed matching load to r6
    tick();
    drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    chk_b("r3_ld", 1'b0, 16'h0000);
    tick();
    drive(4'd6, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
    chk_a("flush", 1'b0, 16'h0000);
    chk_b("flush", 1'b0, 16'h0008);
    tick();
    drive(4'd6, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    chk_b("post_flush", 1'b1, 16'h0008);
    tick();
    chk_b("r3_done", 1'b0, 16'h0000);

    // reset in the middle of a stall window
    tick();
    drive(4'd4, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    chk_b("mid_t0", 1'b1, 16'h0000);
    tick();
    drive(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_b("mid_rst", 1'b0, 16'h0010);
    tick();
    rst = 1'b0;
    #1;
    chk_b("mid_after", 1'b0, 16'h0000);
    chk("mid_b_scnt", 32'(b_scnt), 32'd0);
    chk("mid_c_scnt", 32'(c_scnt), 32'd0);

    // two independent load-use pairs for the statistics counter
    tick();
    drive(4'd2, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    chk_b("p1_t0", 1'b1, 16'h0000);
    tick();
    drive(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk_b("p1_t3", 1'b0, 16'h0000);
    drive(4'd0, 1'b0, 4'd11, 1'b1, 4'd11, 1'b1, 1'b0);
    chk_b("p2_t0", 1'b1, 16'h0000);
    tick();
    drive(4'd0, 1'b0, 4'd11, 1'b1, 4'd0, 1'b0, 1'b0);
    chk_b("p2_t1", 1'b1, 16'h0800);
    tick();
    tick();
    chk_b("p2_t3", 1'b0, 16'h0000);
    chk("stat_a", 32'(a_scnt), STATS ? 32'd2 : 32'd0);
    chk("stat_b", 32'(b_scnt), STATS ? 32'd6 : 32'd0);
    chk("stat_c_sat", 32'(c_scnt), STATS ? 32'd3 : 32'd0);
    $display("stats: a=%0d b=%0d c=%0d", a_scnt, b_scnt, c_scnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
